ex_muldiv_unit: RTL and testbench

- EX-stage consumer of the ID/EX pipeline register outputs for RV32M instructions: iterative multiply/divide/remainder unit.
- While the ID/EX register presents an M-extension op, the unit holds the pipeline via a stall output, iterates, and returns a registered result with a one-cycle done pulse.
- On done, the pipeline advances and the result flows into EX/MEM like any ALU result.

---
 rtl/ex_muldiv_if.sv | 28 ++
 rtl/ex_muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// ID/EX-to-muldiv handshake and operand bundle.
// The pipeline side is the master; the EX-stage multiply/divide unit is the slave.
interface ex_muldiv_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  start;
  logic                  flush;
  logic [2:0]            funct3;
  logic [XLEN-1:0]       rs1_val;
  logic [XLEN-1:0]       rs2_val;
  logic [REG_ADDR_W-1:0] rd_in;
  logic                  stall;
  logic                  busy;
  logic                  done;
  logic [XLEN-1:0]       result;
  logic [REG_ADDR_W-1:0] rd_out;

  modport master (
    output start, flush, funct3, rs1_val, rs2_val, rd_in,
    input  stall, busy, done, result, rd_out
  );

  modport slave (
    input  start, flush, funct3, rs1_val, rs2_val, rd_in,
    output stall, busy, done, result, rd_out
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide/remainder unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a final sign fix-up.
//
// state  | meaning
// IDLE   | waiting for start; accept latches operands, resolves div-by-zero/overflow directly
// MUL    | shift-add iteration, one multiplier bit per cycle
// DIV    | restoring division, one quotient bit per cycle
// FIX    | apply result sign, select half, register result
// DONE   | one-cycle done pulse, then back to IDLE
module ex_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic         clk,
  input logic         rst,
  ex_muldiv_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [2*XLEN-1:0]     r_prod;
  logic [XLEN-1:0]       r_opb;
  logic [XLEN-1:0]       r_result;
  logic [REG_ADDR_W-1:0] r_rd_pend;
  logic [REG_ADDR_W-1:0] r_rd_out;
  logic                  r_neg;
  logic                  r_sel_hi;
  logic                  r_is_div;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]       w_mag_a, w_mag_b;
  logic                  w_div0, w_ovf, w_special;
  logic [XLEN-1:0]       w_special_res;
  logic                  w_last;
  logic [XLEN:0]         w_mul_sum;
  logic [XLEN:0]         w_div_shift, w_div_diff;
  logic [2*XLEN-1:0]     w_prod_signed;
  logic [XLEN-1:0]       w_mul_res, w_div_raw, w_div_res, w_fix_res;

  assign bus.stall  = bus.start & ~r_done;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.rd_out = r_rd_out;

  // Operand decode at accept
  assign w_a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign w_b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b110);
  assign w_a_neg = w_a_signed & bus.rs1_val[XLEN-1];
  assign w_b_neg = w_b_signed & bus.rs2_val[XLEN-1];
  assign w_mag_a = w_a_neg ? -bus.rs1_val : bus.rs1_val;
  assign w_mag_b = w_b_neg ? -bus.rs2_val : bus.rs2_val;

  assign w_div0    = bus.funct3[2] & (bus.rs2_val == '0);
  assign w_ovf     = bus.funct3[2] & ~bus.funct3[0] & (bus.rs1_val == MIN_NEG) &
                     (bus.rs2_val == '1);
  assign w_special = w_div0 | w_ovf;
  assign w_special_res = w_div0 ? (bus.funct3[1] ? bus.rs1_val : '1)
                                : (bus.funct3[1] ? '0 : MIN_NEG);

  assign w_last = (r_cnt == CW'(XLEN-1));

  // Multiply keeps {accumulator, remaining multiplier}; divide keeps {remainder, quotient}
  assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, (r_prod[0] ? r_opb : '0)};
  assign w_div_shift = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};

  assign w_prod_signed = r_neg ? -r_prod : r_prod;
  assign w_mul_res = r_sel_hi ? w_prod_signed[2*XLEN-1:XLEN] : w_prod_signed[XLEN-1:0];
  assign w_div_raw = r_sel_hi ? r_prod[2*XLEN-1:XLEN] : r_prod[XLEN-1:0];
  assign w_div_res = r_neg ? -w_div_raw : w_div_raw;
  assign w_fix_res = r_is_div ? w_div_res : w_mul_res;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_special)          w_state_nxt = S_DONE;
            else if (bus.funct3[2]) w_state_nxt = S_DIV;
            else                    w_state_nxt = S_MUL;
          end
        end
        S_MUL:   if (w_last) w_state_nxt = S_FIX;
        S_DIV:   if (w_last) w_state_nxt = S_FIX;
        S_FIX:   w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_prod    <= '0;
      r_opb     <= '0;
      r_result  <= '0;
      r_rd_pend <= '0;
      r_rd_out  <= '0;
      r_neg     <= 1'b0;
      r_sel_hi  <= 1'b0;
      r_is_div  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_MUL) || (w_state_nxt == S_DIV) || (w_state_nxt == S_FIX);
      r_done <= (w_state_nxt == S_DONE);
      if (!bus.flush) begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_rd_pend <= bus.rd_in;
              r_cnt     <= '0;
              r_is_div  <= bus.funct3[2];
              r_sel_hi  <= bus.funct3[2] ? bus.funct3[1] : (bus.funct3 != 3'b000);
              if (bus.funct3[2]) begin
                r_neg  <= bus.funct3[1] ? w_a_neg : (w_a_neg ^ w_b_neg);
                r_prod <= {{XLEN{1'b0}}, w_mag_a};
                r_opb  <= w_mag_b;
              end else begin
                r_neg  <= w_a_neg ^ w_b_neg;
                r_prod <= {{XLEN{1'b0}}, w_mag_b};
                r_opb  <= w_mag_a;
              end
              if (w_special) begin
                r_result <= w_special_res;
                r_rd_out <= bus.rd_in;
              end
            end
          end
          S_MUL: begin
            r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
            r_cnt  <= r_cnt + CW'(1);
          end
          S_DIV: begin
            if (!w_div_diff[XLEN])
              r_prod <= {w_div_diff[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};
            else
              r_prod <= {w_div_shift[XLEN-1:0], r_prod[XLEN-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
          end
          S_FIX: begin
            r_result <= w_fix_res;
            r_rd_out <= r_rd_pend;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV32M vectors, special cases, flush and reset
// abort, with a monitor that checks every done pulse against queued expectations.
module tb_ex_muldiv_unit;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  ex_muldiv_if #(.XLEN(32), .REG_ADDR_W(5)) bus();

  ex_muldiv_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that follows the done cycle.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input bit special);
    int   stall_n = 0;
    int   busy_n = 0;
    bit   seen = 0;
    exp_t e;
    bus.funct3  = f3;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
    bus.start   = 1'b1;
    e.res      = exp_res;
    e.rd       = rd;
    e.done_cyc = cyc + 1 + (special ? 0 : 33);
    sb_q.push_back(e);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      else begin
        stall_n += int'(bus.stall);
        busy_n  += int'(bus.busy);
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("stall_cycles", stall_n, special ? 32'd1 : 32'd34);
    chk("busy_cycles", busy_n, special ? 32'd0 : 32'd33);
    chk("stall_at_done", 32'(bus.stall), 32'd0);
    last_res = exp_res;
    last_rd  = rd;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got result %h rd %0d expected no done (cycle %0d)",
                   bus.result, bus.rd_out, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("result", bus.result, e.res);
          chk("rd_out", 32'(bus.rd_out), 32'(e.rd));
          chk("done_cycle", cyc, e.done_cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.rs1_val = '0; bus.rs2_val = '0; bus.rd_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_rd_out", 32'(bus.rd_out), 32'd0);
    bus.start = 1'b1; #1;
    chk("rst_stall", 32'(bus.stall), 32'd1);
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    do_op(3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 0); // MUL
    do_op(3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 0); // MULH
    do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 0); // MULHU
    do_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 0); // MULHSU
    do_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'h00000001, 0); // MUL
    do_op(3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 0); // DIV
    do_op(3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 0); // REM
    do_op(3'b101, 32'd100,      32'd7,        5'd12, 32'd14,       0); // DIVU
    do_op(3'b111, 32'd100,      32'd7,        5'd13, 32'd2,        0); // REMU
    do_op(3'b100, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1); // DIV by zero
    do_op(3'b110, 32'd5,        32'd0,        5'd15, 32'd5,        1); // REM by zero
    do_op(3'b101, 32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1); // DIVU by zero
    do_op(3'b111, 32'd5,        32'd0,        5'd17, 32'd5,        1); // REMU by zero
    do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1); // DIV overflow
    do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0,        1); // REM overflow
    do_op(3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'd0,        0); // DIVU, not special
    do_op(3'b111, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000, 0); // REMU, not special

    // Flush a DIVU around iteration 10
    bus.funct3 = 3'b101; bus.rs1_val = 32'd100; bus.rs2_val = 32'd7; bus.rd_in = 5'd3;
    bus.start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_done", 32'(bus.done), 32'd0);
    chk("flush_result", bus.result, last_res);
    chk("flush_rd_out", 32'(bus.rd_out), 32'(last_rd));
    @(posedge clk); #1;
    do_op(3'b000, 32'd3, 32'd4, 5'd22, 32'd12, 0);

    // Flush coincident with start in IDLE discards the start
    bus.funct3 = 3'b000; bus.rs1_val = 32'd9; bus.rs2_val = 32'd9; bus.rd_in = 5'd1;
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;

    // Reset around iteration 20 of a MUL
    bus.funct3 = 3'b000; bus.rs1_val = 32'd11; bus.rs2_val = 32'd13; bus.rd_in = 5'd4;
    bus.start = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_done", 32'(bus.done), 32'd0);
    chk("rst_mid_result", bus.result, 32'd0);
    chk("rst_mid_rd_out", 32'(bus.rd_out), 32'd0);
    @(posedge clk); #1;
    do_op(3'b011, 32'h00010000, 32'h00010000, 5'd9, 32'd1, 0); // MULHU after reset

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
